// File: rtl/lcd_defs.sv
// Shared definitions for the 16x2 LCD string writer: HD44780 command bytes,
// sequencer state/phase encodings, nibble transmitter states and small helpers.
package lcd_defs;

  // HD44780 command bytes
  localparam logic [7:0] FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] HOME         = 8'h02;
  localparam logic [7:0] LINE1_ADDR   = 8'h80;
  localparam logic [7:0] LINE2_ADDR   = 8'hC0;

  // Top sequencer states
  localparam logic [3:0] ST_PWRUP = 4'd0;
  localparam logic [3:0] ST_INIT  = 4'd1;
  localparam logic [3:0] ST_CFG   = 4'd2;
  localparam logic [3:0] ST_IDLE  = 4'd3;
  localparam logic [3:0] ST_CLR   = 4'd4;
  localparam logic [3:0] ST_ADDR1 = 4'd5;
  localparam logic [3:0] ST_LINE1 = 4'd6;
  localparam logic [3:0] ST_ADDR2 = 4'd7;
  localparam logic [3:0] ST_LINE2 = 4'd8;

  // Phases of one byte (or single init nibble) transfer
  localparam logic [2:0] PH_START = 3'd0;
  localparam logic [2:0] PH_HI    = 3'd1;
  localparam logic [2:0] PH_GAP   = 3'd2;
  localparam logic [2:0] PH_LO    = 3'd3;
  localparam logic [2:0] PH_WAIT  = 3'd4;

  // Nibble transmitter states
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SETUP = 2'd1;
  localparam logic [1:0] TX_EHI   = 2'd2;
  localparam logic [1:0] TX_HOLD  = 2'd3;

  // Timer load value; a zero or negative length still waits one cycle
  function automatic logic [19:0] wait_load(input int cycles);
    if (cycles < 1) return 20'd1;
    else return cycles[19:0];
  endfunction

  // Configuration byte sequence issued after the nibble-mode init
  function automatic logic [7:0] cfg_byte(input logic [1:0] step);
    case (step)
      2'd0:    return FUNC_4BIT_2L;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_INC;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Single-nibble LCD write: presents RS and data, waits two setup cycles,
// raises E for T_EHI cycles, drops E and holds RS/data one more cycle, then
// signals ack for that cycle. RS/data keep their value afterwards.
module lcd_nibble_tx
  import lcd_defs::*;
#(
  parameter int T_EHI = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rs,
  input  logic [3:0] nib,
  output logic       ack,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [3:0] lcd_dat
);

  localparam logic [19:0] EHI_LOAD = (T_EHI <= 1) ? 20'd0 : wait_load(T_EHI - 1);

  logic [1:0]  state_r;
  logic [19:0] cnt_r;

  assign ack = (state_r == TX_HOLD);

  // Nibble timing state machine; all LCD pins are registered so reset forces E low cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= TX_IDLE;
      cnt_r   <= 20'd0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_dat <= 4'h0;
    end else begin
      case (state_r)
        TX_IDLE: begin
          if (req) begin
            lcd_rs  <= rs;
            lcd_dat <= nib;
            cnt_r   <= 20'd1;
            state_r <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (cnt_r == 20'd0) begin
            lcd_e   <= 1'b1;
            cnt_r   <= EHI_LOAD;
            state_r <= TX_EHI;
          end else begin
            cnt_r <= cnt_r - 20'd1;
          end
        end
        TX_EHI: begin
          if (cnt_r == 20'd0) begin
            lcd_e   <= 1'b0;
            state_r <= TX_HOLD;
          end else begin
            cnt_r <= cnt_r - 20'd1;
          end
        end
        TX_HOLD: state_r <= TX_IDLE;
        default: begin
          lcd_e   <= 1'b0;
          state_r <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_string_writer.sv
// 16x2 HD44780 string writer (4-bit, write-only). Runs power-up init, then
// rewrites both lines from a latched 32-char frame on every cls request.
// Optional feature: define LCD_CLEAR_ON_REFRESH_EN to issue a display clear
// (0x01, long wait) at the start of every refresh.
module lcd_string_writer
  import lcd_defs::*;
#(
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000,
  parameter int T_EHI   = 12,
  parameter int T_GAP   = 50
) (
  input  logic         CCLK,
  input  logic         rst,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         busy,
  output logic         done,
  output logic         LCDE,
  output logic         LCDRS,
  output logic         LCDRW,
  output logic [3:0]   LCDDAT
);

  localparam logic [19:0] LD_PWRUP = wait_load(T_PWRUP);
  localparam logic [19:0] LD_INIT1 = wait_load(T_INIT1);
  localparam logic [19:0] LD_INIT2 = wait_load(T_INIT2);
  localparam logic [19:0] LD_CMD   = wait_load(T_CMD);
  localparam logic [19:0] LD_CLR   = wait_load(T_CLR);
  localparam logic [19:0] LD_GAP   = wait_load(T_GAP);

`ifdef LCD_CLEAR_ON_REFRESH_EN
  localparam logic [3:0] REFRESH_FIRST = ST_CLR;
`else
  localparam logic [3:0] REFRESH_FIRST = ST_ADDR1;
`endif

  logic [3:0]   state_r;
  logic [2:0]   phase_r;
  logic [4:0]   idx_r;
  logic [19:0]  timer_r;
  logic [255:0] frame_r;
  logic         pending_r;
  logic         busy_r;
  logic         done_r;
  logic         req_r;
  logic         tx_rs_r;
  logic [3:0]   tx_nib_r;

  logic         tx_ack_s;
  logic [7:0]   cur_byte_s;
  logic         cur_rs_s;
  logic         nibble_only_s;
  logic [19:0]  init_wait_s;
  logic         clr_like_s;
  logic [19:0]  byte_wait_s;
  logic         expired_s;
  logic         step_done_s;
  logic         last_step_s;
  logic         finish_s;
  logic         start_s;

  assign busy  = busy_r;
  assign done  = done_r;
  assign LCDRW = 1'b0;

  lcd_nibble_tx #(.T_EHI(T_EHI)) u_tx (
    .clk    (CCLK),
    .rst    (rst),
    .req    (req_r),
    .rs     (tx_rs_r),
    .nib    (tx_nib_r),
    .ack    (tx_ack_s),
    .lcd_e  (LCDE),
    .lcd_rs (LCDRS),
    .lcd_dat(LCDDAT)
  );

  // Decode the byte for the current step, its post-write wait, and step/refresh boundaries
  always_comb begin
    cur_byte_s    = 8'h00;
    cur_rs_s      = 1'b0;
    nibble_only_s = 1'b0;
    init_wait_s   = LD_CMD;
    case (state_r)
      ST_INIT: begin
        nibble_only_s = 1'b1;
        cur_byte_s    = (idx_r == 5'd3) ? 8'h02 : 8'h03;
        if (idx_r == 5'd0) init_wait_s = LD_INIT1;
        else if (idx_r == 5'd1) init_wait_s = LD_INIT2;
        else init_wait_s = LD_CMD;
      end
      ST_CFG:   cur_byte_s = cfg_byte(idx_r[1:0]);
      ST_CLR:   cur_byte_s = CLEAR;
      ST_ADDR1: cur_byte_s = LINE1_ADDR;
      ST_ADDR2: cur_byte_s = LINE2_ADDR;
      ST_LINE1, ST_LINE2: begin
        cur_byte_s = frame_r[{~idx_r, 3'b000} +: 8];
        cur_rs_s   = 1'b1;
      end
      default: cur_byte_s = 8'h00;
    endcase
    clr_like_s  = !cur_rs_s && ((cur_byte_s == CLEAR) || (cur_byte_s == HOME));
    byte_wait_s = nibble_only_s ? init_wait_s : (clr_like_s ? LD_CLR : LD_CMD);
    expired_s   = (timer_r <= 20'd1);
    step_done_s = (phase_r == PH_WAIT) && expired_s &&
                  (state_r != ST_PWRUP) && (state_r != ST_IDLE);
    last_step_s = ((state_r == ST_CFG) && (idx_r == 5'd3)) ||
                  ((state_r == ST_LINE2) && (idx_r == 5'd31));
    finish_s    = step_done_s && last_step_s;
    start_s     = ((state_r == ST_IDLE) && (cls || pending_r)) || (finish_s && pending_r);
  end

  // Sequencer: power-up wait, per-byte nibble/gap/wait phases, frame latch and pending request
  always_ff @(posedge CCLK) begin
    if (rst) begin
      state_r   <= ST_PWRUP;
      phase_r   <= PH_START;
      idx_r     <= 5'd0;
      timer_r   <= LD_PWRUP;
      frame_r   <= 256'd0;
      pending_r <= 1'b0;
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      req_r     <= 1'b0;
      tx_rs_r   <= 1'b0;
      tx_nib_r  <= 4'h0;
    end else begin
      req_r  <= 1'b0;
      done_r <= step_done_s && (state_r == ST_LINE2) && (idx_r == 5'd31);
      case (state_r)
        ST_PWRUP: begin
          if (expired_s) begin
            state_r <= ST_INIT;
            idx_r   <= 5'd0;
            phase_r <= PH_START;
          end else begin
            timer_r <= timer_r - 20'd1;
          end
        end
        ST_IDLE: phase_r <= PH_START;
        default: begin
          case (phase_r)
            PH_START: begin
              req_r    <= 1'b1;
              tx_rs_r  <= cur_rs_s;
              tx_nib_r <= nibble_only_s ? cur_byte_s[3:0] : cur_byte_s[7:4];
              phase_r  <= PH_HI;
            end
            PH_HI: begin
              if (tx_ack_s) begin
                timer_r <= nibble_only_s ? byte_wait_s : LD_GAP;
                phase_r <= nibble_only_s ? PH_WAIT : PH_GAP;
              end
            end
            PH_GAP: begin
              if (expired_s) begin
                req_r    <= 1'b1;
                tx_rs_r  <= cur_rs_s;
                tx_nib_r <= cur_byte_s[3:0];
                phase_r  <= PH_LO;
              end else begin
                timer_r <= timer_r - 20'd1;
              end
            end
            PH_LO: begin
              if (tx_ack_s) begin
                timer_r <= byte_wait_s;
                phase_r <= PH_WAIT;
              end
            end
            PH_WAIT: begin
              if (expired_s) begin
                phase_r <= PH_START;
                case (state_r)
                  ST_INIT: begin
                    if (idx_r == 5'd3) begin
                      state_r <= ST_CFG;
                      idx_r   <= 5'd0;
                    end else begin
                      idx_r <= idx_r + 5'd1;
                    end
                  end
                  ST_CFG: idx_r <= idx_r + 5'd1;
                  ST_CLR: begin
                    state_r <= ST_ADDR1;
                    idx_r   <= 5'd0;
                  end
                  ST_ADDR1: begin
                    state_r <= ST_LINE1;
                    idx_r   <= 5'd0;
                  end
                  ST_LINE1: begin
                    if (idx_r == 5'd15) begin
                      state_r <= ST_ADDR2;
                      idx_r   <= 5'd16;
                    end else begin
                      idx_r <= idx_r + 5'd1;
                    end
                  end
                  ST_ADDR2: state_r <= ST_LINE2;
                  ST_LINE2: begin
                    if (idx_r != 5'd31) idx_r <= idx_r + 5'd1;
                  end
                  default: state_r <= ST_IDLE;
                endcase
              end else begin
                timer_r <= timer_r - 20'd1;
              end
            end
            default: phase_r <= PH_START;
          endcase
        end
      endcase
      // Refresh start / end override the step advance above
      if (start_s) begin
        frame_r   <= strdata;
        pending_r <= 1'b0;
        busy_r    <= 1'b1;
        state_r   <= REFRESH_FIRST;
        idx_r     <= 5'd0;
        phase_r   <= PH_START;
      end else begin
        if (finish_s) begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        if (cls && busy_r) pending_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_string_writer.sv
// Self-checking bench for lcd_string_writer: captures every LCD E pulse as
// {RS,nibble}, compares against a stream built from the command/frame rules,
// and checks setup/hold stability, RW low, busy/done behaviour and resets.
module tb_lcd_string_writer;

  logic         CCLK = 1'b0;
  logic         rst;
  logic         cls;
  logic [255:0] strdata;
  logic         busy, done, LCDE, LCDRS, LCDRW;
  logic [3:0]   LCDDAT;

  int checks = 0;
  int errors = 0;

  logic [4:0] cap_q[$];
  logic [4:0] exp_q[$];
  logic [9:0] stab_q[$];
  int         done_cnt = 0;
  int         rw_bad   = 0;
  logic       prev_e   = 1'b0;
  logic [4:0] prev1    = 5'd0;
  logic [4:0] prev2    = 5'd0;
  logic [4:0] cur_s;
  int         stab_idx = 0;
  int         cap_base = 0;

  assign cur_s = {LCDRS, LCDDAT};

  always #5 CCLK = ~CCLK;

  lcd_string_writer #(
    .T_PWRUP(20), .T_INIT1(10), .T_INIT2(5), .T_CMD(4),
    .T_CLR(8), .T_EHI(2), .T_GAP(3)
  ) dut (
    .CCLK(CCLK), .rst(rst), .cls(cls), .strdata(strdata),
    .busy(busy), .done(done), .LCDE(LCDE), .LCDRS(LCDRS),
    .LCDRW(LCDRW), .LCDDAT(LCDDAT)
  );

  // Bus monitor: records nibbles at E rise, stability pairs, done pulses, RW violations
  always @(negedge CCLK) begin
    if (rst === 1'b0) begin
      if (LCDRW !== 1'b0) rw_bad <= rw_bad + 1;
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (LCDE === 1'b1 && prev_e === 1'b0) begin
        cap_q.push_back(cur_s);
        stab_q.push_back({prev2, cur_s});
        stab_q.push_back({prev1, cur_s});
      end else if (LCDE === 1'b1 && prev_e === 1'b1) begin
        stab_q.push_back({prev1, cur_s});
      end else if (LCDE === 1'b0 && prev_e === 1'b1) begin
        stab_q.push_back({prev1, cur_s});
      end
    end
    prev_e <= LCDE;
    prev1  <= cur_s;
    prev2  <= prev1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CCLK);
  endtask

  task automatic pulse_cls();
    cls = 1'b1;
    tick(1);
    cls = 1'b0;
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  // Reference: power-up sequence as seen on the bus
  task automatic add_init();
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h02);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
  endtask

  // Reference: one refresh of a 32-char frame, char 0 in the top byte
  task automatic add_refresh(input logic [255:0] f);
`ifdef LCD_CLEAR_ON_REFRESH_EN
    push_byte(1'b0, 8'h01);
`endif
    push_byte(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) push_byte(1'b1, f[255 - 8*i -: 8]);
    push_byte(1'b0, 8'hC0);
    for (int i = 16; i < 32; i++) push_byte(1'b1, f[255 - 8*i -: 8]);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, cap_q.size() - cap_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (cap_base + i < cap_q.size()) chk({tag, "_nib"}, cap_q[cap_base + i], exp_q[i]);
    end
    cap_base = cap_q.size();
    exp_q.delete();
    while (stab_idx < stab_q.size()) begin
      chk({tag, "_stable"}, stab_q[stab_idx][4:0], stab_q[stab_idx][9:5]);
      stab_idx++;
    end
    chk({tag, "_lcdrw"}, rw_bad, 0);
  endtask

  task automatic wait_busy_low(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_done_cnt"}, done_cnt, target);
  endtask

  function automatic logic [255:0] rand_frame();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = $urandom;
    return f;
  endfunction

  initial begin
    int d0;
    int n;
    logic [255:0] f;
    rst = 1'b1;
    cls = 1'b0;
    strdata = 256'd0;
    tick(3);

    // Reset state
    chk("rst_lcde", LCDE, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_dat", LCDDAT, 4'h0);
    chk("rst_rs", LCDRS, 1'b0);
    chk("rst_rw", LCDRW, 1'b0);
    rst = 1'b0;

    // Power-up init without any request
    d0 = done_cnt;
    add_init();
    wait_busy_low(3000, "init");
    tick(2);
    check_stream("init");
    chk("init_no_done", done_cnt, d0);

    // Directed frame refresh
    strdata = "01234567 00 0123f01d01e01m01w01 ";
    add_refresh(strdata);
    d0 = done_cnt;
    pulse_cls();
    chk("t2_busy_high", busy, 1'b1);
    wait_done(d0 + 1, 5000, "t2");
    wait_busy_low(100, "t2");
    tick(50);
    chk("t2_one_done", done_cnt, d0 + 1);
    check_stream("t2");

    // Requests during a refresh coalesce; frame in flight is unaffected
    f = rand_frame();
    strdata = f;
    add_refresh(f);
    d0 = done_cnt;
    pulse_cls();
    tick($urandom_range(200, 30));
    strdata = {32{8'h41}};
    pulse_cls();
    tick($urandom_range(40, 5));
    pulse_cls();
    add_refresh({32{8'h41}});
    wait_done(d0 + 2, 8000, "t3");
    wait_busy_low(100, "t3");
    tick(300);
    chk("t3_two_done", done_cnt, d0 + 2);
    chk("t3_idle", busy, 1'b0);
    check_stream("t3");

    // Random frames; strdata changes without cls must not leak into the refresh
    for (int k = 0; k < 3; k++) begin
      f = rand_frame();
      strdata = f;
      add_refresh(f);
      d0 = done_cnt;
      pulse_cls();
      tick($urandom_range(300, 10));
      strdata = rand_frame();
      wait_done(d0 + 1, 5000, "rnd");
      wait_busy_low(100, "rnd");
      check_stream("rnd");
    end

    // Reset while a LINE1 data nibble has E high, then cls during the replayed init
    strdata = rand_frame();
    pulse_cls();
    n = 0;
    while (!(LCDE === 1'b1 && LCDRS === 1'b1) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("t4_found_ehigh", {LCDE, LCDRS}, 2'b11);
    rst = 1'b1;
    tick(1);
    chk("t4_lcde_low", LCDE, 1'b0);
    chk("t4_busy_high", busy, 1'b1);
    chk("t4_done_low", done, 1'b0);
    tick(2);
    rst = 1'b0;
    cap_base = cap_q.size();
    exp_q.delete();
    d0 = done_cnt;
    tick(5);
    f = rand_frame();
    strdata = f;
    pulse_cls();
    chk("t4_busy_in_init", busy, 1'b1);
    add_init();
    add_refresh(f);
    wait_done(d0 + 1, 8000, "t4");
    wait_busy_low(100, "t4");
    tick(20);
    check_stream("t4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
